// File: rtl/mem_port_master.sv
// mem_port_master: valid/ready burst read/write initiator driving the DFF word memory pins (cmd_*, wd_* in; mem_* to memory; rsp_* out)
module mem_port_master #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 4,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [DATA_W-1:0] wd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_last
);
  localparam int CW = $clog2(RD_LAT + 1) + 1;
  typedef enum logic [2:0] {IDLE, WR, WR_RSP, RD_ADDR, RD_WAIT, RD_RSP} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr, addr_n, mem_addr_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic [CW-1:0] lat, lat_n;
  logic [DATA_W-1:0] mem_wdata_n, rsp_rdata_n;
  logic cmd_ready_n, wd_ready_n, mem_we_n, rsp_valid_n, rsp_last_n, beat, last;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      cnt       <= '0;
      lat       <= '0;
      cmd_ready <= 1'b0;
      wd_ready  <= 1'b0;
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_last  <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      cnt       <= cnt_n;
      lat       <= lat_n;
      cmd_ready <= cmd_ready_n;
      wd_ready  <= wd_ready_n;
      mem_addr  <= mem_addr_n;
      mem_we    <= mem_we_n;
      mem_wdata <= mem_wdata_n;
      rsp_valid <= rsp_valid_n;
      rsp_rdata <= rsp_rdata_n;
      rsp_last  <= rsp_last_n;
    end
  end
  always_comb begin
    state_n     = state;
    addr_n      = addr;
    cnt_n       = cnt;
    lat_n       = lat;
    cmd_ready_n = cmd_ready;
    wd_ready_n  = wd_ready;
    mem_addr_n  = mem_addr;
    mem_we_n    = 1'b0;
    mem_wdata_n = mem_wdata;
    rsp_valid_n = rsp_valid;
    rsp_rdata_n = rsp_rdata;
    rsp_last_n  = rsp_last;
    beat        = wd_valid && wd_ready;
    last        = cnt == '0;
    case (state)
      IDLE: begin
        cmd_ready_n = 1'b1;
        if (cmd_valid && cmd_ready) begin
          cmd_ready_n = 1'b0;
          addr_n      = cmd_addr;
          cnt_n       = cmd_len;
          lat_n       = '0;
          wd_ready_n  = cmd_we;
          state_n     = cmd_we ? WR : RD_ADDR;
        end
      end
      WR: begin
        if (beat) begin
          mem_we_n    = 1'b1;
          mem_addr_n  = addr;
          mem_wdata_n = wd_data;
          addr_n      = addr + 1'b1;
          cnt_n       = cnt - 1'b1;
          wd_ready_n  = !last;
          state_n     = last ? WR_RSP : WR;
        end
      end
      WR_RSP: begin
        rsp_valid_n = !(rsp_valid && rsp_ready);
        rsp_last_n  = !(rsp_valid && rsp_ready);
        rsp_rdata_n = '0;
        cmd_ready_n = rsp_valid && rsp_ready;
        state_n     = (rsp_valid && rsp_ready) ? IDLE : WR_RSP;
      end
      RD_ADDR: begin
        mem_addr_n = addr;
        state_n    = RD_WAIT;
      end
      RD_WAIT: begin
        if (lat == CW'(RD_LAT)) begin
          rsp_valid_n = 1'b1;
          rsp_rdata_n = mem_rdata;
          rsp_last_n  = last;
          state_n     = RD_RSP;
        end else begin
          lat_n = lat + 1'b1;
        end
      end
      RD_RSP: begin
        // the next beat's address is presented at handshake so that cycle already counts toward the read latency
        if (rsp_ready) begin
          rsp_valid_n = 1'b0;
          rsp_last_n  = 1'b0;
          addr_n      = addr + 1'b1;
          cnt_n       = cnt - 1'b1;
          cmd_ready_n = last;
          mem_addr_n  = last ? mem_addr : addr + 1'b1;
          lat_n       = CW'(1);
          state_n     = last ? IDLE : RD_ADDR;
        end
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: scoreboard bench for mem_port_master with a one-cycle synchronous memory model
module tb_mem_port_master;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic preload = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_we = 1'b0;
  logic [11:0] cmd_addr = '0;
  logic [3:0] cmd_len = '0;
  logic wd_valid = 1'b0;
  logic [15:0] wd_data = '0;
  logic rsp_ready = 1'b1;
  logic cmd_ready, wd_ready, mem_we, rsp_valid, rsp_last;
  logic [11:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata, rsp_rdata;
  logic [15:0] mem [0:4095];
  logic [15:0] exp_mem [0:4095];
  logic [15:0] wd_q [0:15];
  logic [16:0] rq[$];
  logic [27:0] wq[$];
  int checks = 0;
  int errors = 0;
  int hs = 0;
  int acc = 0;
  int pulses = 0;
  mem_port_master dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_last(rsp_last)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 16'(i);
    end else begin
      if (mem_we === 1'b1) mem[mem_addr] <= mem_wdata;
      mem_rdata <= mem[mem_addr];
    end
  end
  task automatic step();
    logic [16:0] e;
    logic [27:0] w;
    if (rsp_valid === 1'b1 && rsp_ready) begin
      checks++;
      hs++;
      if (rq.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got last=%b data=%h want none", rsp_last, rsp_rdata);
      end else begin
        e = rq.pop_front();
        if ({rsp_last, rsp_rdata} !== e) begin
          errors++;
          $display("FAIL rsp got last=%b data=%h want last=%b data=%h", rsp_last, rsp_rdata, e[16], e[15:0]);
        end
      end
    end
    if (cmd_valid && cmd_ready === 1'b1) acc++;
    @(posedge clk);
    @(negedge clk);
    if (mem_we === 1'b1) begin
      checks++;
      pulses++;
      if (wq.size() == 0) begin
        errors++;
        $display("FAIL mem_we_unexpected got addr=%h data=%h want none", mem_addr, mem_wdata);
      end else begin
        w = wq.pop_front();
        if ({mem_addr, mem_wdata} !== w) begin
          errors++;
          $display("FAIL mem_write got addr=%h data=%h want addr=%h data=%h", mem_addr, mem_wdata, w[27:16], w[15:0]);
        end
      end
    end
  endtask
  task automatic send_cmd(input logic we, input logic [11:0] a, input logic [3:0] len);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    checks++;
    if (k == 50) begin
      errors++;
      $display("FAIL cmd_ready_timeout got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_addr = a;
    cmd_len = len;
    if (we) rq.push_back({1'b1, 16'h0000});
    else for (int i = 0; i <= int'(len); i++) rq.push_back({i == int'(len), exp_mem[a + 12'(i)]});
    step();
    cmd_valid = 1'b0;
  endtask
  task automatic write_burst(input logic [11:0] a, input int n, input logic [31:0] pat, input int plen);
    int i = 0;
    int c = 0;
    logic took;
    logic [11:0] ai;
    while (i < n && c < 100) begin
      wd_valid = (c < plen) ? pat[c] : 1'b1;
      wd_data = wd_q[i];
      took = wd_valid && wd_ready === 1'b1;
      if (took) begin
        ai = a + 12'(i);
        wq.push_back({ai, wd_q[i]});
        exp_mem[ai] = wd_q[i];
      end
      step();
      if (took) i++;
      c++;
    end
    wd_valid = 1'b0;
    checks++;
    if (i != n) begin
      errors++;
      $display("FAIL wd_accept got %0d beats want %0d", i, n);
    end
  endtask
  task automatic settle();
    int k = 0;
    while ((rq.size() != 0 || wq.size() != 0) && k < 100) begin
      step();
      k++;
    end
    for (int j = 0; j < 3; j++) step();
  endtask
  task automatic test_reset();
    rst = 1'b1;
    step();
    preload = 1'b0;
    checks++;
    if ({cmd_ready, wd_ready, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_last} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cr=%b wr=%b we=%b a=%h wd=%h rv=%b rd=%h rl=%b want all 0",
               cmd_ready, wd_ready, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_rdata, rsp_last);
    end
    rst = 1'b0;
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_cmd_ready got %b want 1", cmd_ready);
    end
  endtask
  task automatic test_write_read();
    int p0 = pulses;
    int n = 0;
    wd_q[0] = 16'h1253;
    send_cmd(1'b1, 12'h007, 4'd0);
    write_burst(12'h007, 1, 32'hFFFF_FFFF, 0);
    settle();
    checks++;
    if (pulses - p0 != 1) begin
      errors++;
      $display("FAIL write_pulses got %0d want 1", pulses - p0);
    end
    send_cmd(1'b0, 12'h007, 4'd0);
    while (rsp_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != 3) begin
      errors++;
      $display("FAIL read_latency got %0d want 3", n);
    end
    checks++;
    if ({rsp_last, rsp_rdata} !== {1'b1, 16'h1253}) begin
      errors++;
      $display("FAIL read_data got last=%b data=%h want last=1 data=1253", rsp_last, rsp_rdata);
    end
    settle();
    checks++;
    if (rq.size() + wq.size() != 0) begin
      errors++;
      $display("FAIL write_read_pending got %0d want 0", rq.size() + wq.size());
    end
  endtask
  task automatic test_wrap();
    int h0 = hs;
    send_cmd(1'b0, 12'hFFE, 4'd3);
    settle();
    checks++;
    if (hs - h0 != 4 || rq.size() != 0) begin
      errors++;
      $display("FAIL wrap_beats got %0d pending %0d want 4 pending 0", hs - h0, rq.size());
    end
  endtask
  task automatic test_backpressure();
    int h0 = hs;
    int k = 0;
    send_cmd(1'b0, 12'h100, 4'd3);
    while (hs - h0 < 1 && k < 50) begin
      step();
      k++;
    end
    rsp_ready = 1'b0;
    k = 0;
    while (rsp_valid !== 1'b1 && k < 50) begin
      step();
      k++;
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if ({rsp_valid, rsp_rdata, mem_addr} !== {1'b1, 16'h0101, 12'h101}) begin
        errors++;
        $display("FAIL hold_cycle%0d got rv=%b rd=%h a=%h want rv=1 rd=0101 a=101", j, rsp_valid, rsp_rdata, mem_addr);
      end
      step();
    end
    rsp_ready = 1'b1;
    settle();
    checks++;
    if (hs - h0 != 4 || rq.size() != 0) begin
      errors++;
      $display("FAIL backpressure_beats got %0d pending %0d want 4 pending 0", hs - h0, rq.size());
    end
  endtask
  task automatic test_write_gaps();
    int p0 = pulses;
    int h0 = hs;
    wd_q[0] = 16'hA1A1;
    wd_q[1] = 16'hB2B2;
    wd_q[2] = 16'hC3C3;
    send_cmd(1'b1, 12'h010, 4'd2);
    write_burst(12'h010, 3, 32'b101001, 6);
    settle();
    checks++;
    if (pulses - p0 != 3 || hs - h0 != 1 || rq.size() + wq.size() != 0) begin
      errors++;
      $display("FAIL gaps got pulses=%0d rsp=%0d want pulses=3 rsp=1", pulses - p0, hs - h0);
    end
  endtask
  task automatic test_reset_mid();
    wd_q[0] = 16'h1111;
    wd_q[1] = 16'h2222;
    send_cmd(1'b1, 12'h020, 4'd3);
    wd_valid = 1'b1;
    wd_data = wd_q[0];
    wq.push_back({12'h020, wd_q[0]});
    exp_mem[12'h020] = wd_q[0];
    step();
    wd_data = wd_q[1];
    rst = 1'b1;
    step();
    checks++;
    if ({mem_we, rsp_valid, wd_ready, cmd_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid got we=%b rv=%b wr=%b cr=%b want 0000", mem_we, rsp_valid, wd_ready, cmd_ready);
    end
    rst = 1'b0;
    wd_valid = 1'b0;
    rq.delete();
    wq.delete();
    step();
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release got %b want 1", cmd_ready);
    end
    send_cmd(1'b0, 12'h007, 4'd0);
    settle();
    checks++;
    if (rq.size() + wq.size() != 0) begin
      errors++;
      $display("FAIL reset_mid_pending got %0d want 0", rq.size() + wq.size());
    end
  endtask
  task automatic test_busy();
    int a0 = acc;
    int k = 0;
    send_cmd(1'b0, 12'h200, 4'd3);
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_addr = 12'h007;
    cmd_len = 4'd0;
    while (rq.size() != 0 && k < 100) begin
      checks++;
      if (cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL busy_cmd_ready got %b want 0", cmd_ready);
      end
      step();
      k++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy_idle_ready got %b want 1", cmd_ready);
    end
    rq.push_back({1'b1, exp_mem[12'h007]});
    step();
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL busy_second_accept got %b want 0", cmd_ready);
    end
    settle();
    checks++;
    if (acc - a0 != 2 || rq.size() != 0) begin
      errors++;
      $display("FAIL busy_accepts got %0d pending %0d want 2 pending 0", acc - a0, rq.size());
    end
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) exp_mem[i] = 16'(i);
    test_reset();
    test_write_read();
    test_wrap();
    test_backpressure();
    test_write_gaps();
    test_reset_mid();
    test_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
